// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path.
// Opcode, funct, ALU operation, select and state codes.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_SLL = 6'h00;
  localparam logic [5:0] F_SRL = 6'h02;
  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_NOR = 6'h27;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_NOR = 4'b0010;
  localparam logic [3:0] ALU_ADD = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0100;
  localparam logic [3:0] ALU_SRL = 4'b1100;
  localparam logic [3:0] ALU_SLL = 4'b1110;

  localparam logic [1:0] SRCA_PC = 2'b00;
  localparam logic [1:0] SRCA_A  = 2'b01;
  localparam logic [1:0] SRCA_B  = 2'b10;

  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BTGT = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_I_EXEC    = 4'd10,
    S_I_WB      = 4'd11
  } state_t;

endpackage

// File: rtl/alu_op_decode.sv
// R-type funct decoder: ALU operation, shift operand
// select and legality flag.
module alu_op_decode
  import mips_ctrl_pkg::*;
#(
  parameter bit ENABLE_SHIFTS = 1'b1
) (
  input  logic [5:0] funct,
  output logic [3:0] alu_op,
  output logic       src_a_is_b,
  output logic       legal
);

  always_comb begin
    alu_op     = ALU_ADD;
    src_a_is_b = 1'b0;
    legal      = 1'b1;
    case (funct)
      F_ADD: alu_op = ALU_ADD;
      F_SUB: alu_op = ALU_SUB;
      F_AND: alu_op = ALU_AND;
      F_OR:  alu_op = ALU_OR;
      F_NOR: alu_op = ALU_NOR;
      F_SLL: begin
        alu_op     = ALU_SLL;
        src_a_is_b = 1'b1;
        legal      = ENABLE_SHIFTS;
      end
      F_SRL: begin
        alu_op     = ALU_SRL;
        src_a_is_b = 1'b1;
        legal      = ENABLE_SHIFTS;
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS main control FSM: fetch, decode,
// memory, ALU and writeback sequencing.
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter bit SUPPORT_BNE   = 1'b1,
  parameter bit ENABLE_SHIFTS = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       Zero,
  output logic       PCEnable,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       ExtOp,
  output logic [3:0] ALUOperation,
  output logic [1:0] PCSource,
  output logic       Illegal,
  output logic [3:0] State
);

  state_t     state_q, state_d;
  logic [3:0] r_alu_op;
  logic       r_src_a_is_b;
  logic       r_legal;

  alu_op_decode #(
    .ENABLE_SHIFTS(ENABLE_SHIFTS)
  ) u_alu_dec (
    .funct      (funct),
    .alu_op     (r_alu_op),
    .src_a_is_b (r_src_a_is_b),
    .legal      (r_legal)
  );

  logic is_r, is_lw, is_sw, is_beq, is_bne;
  logic is_j, is_addi, is_andi, is_ori;

  assign is_r    = (opcode == OP_RTYPE) && r_legal;
  assign is_lw   = (opcode == OP_LW);
  assign is_sw   = (opcode == OP_SW);
  assign is_beq  = (opcode == OP_BEQ);
  assign is_bne  = SUPPORT_BNE && (opcode == OP_BNE);
  assign is_j    = (opcode == OP_J);
  assign is_addi = (opcode == OP_ADDI);
  assign is_andi = (opcode == OP_ANDI);
  assign is_ori  = (opcode == OP_ORI);

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  assign State = state_q;

  always_comb begin
    state_d      = S_FETCH;
    PCEnable     = 1'b0;
    IorD         = 1'b0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    IRWrite      = 1'b0;
    RegDst       = 1'b0;
    MemtoReg     = 1'b0;
    RegWrite     = 1'b0;
    ALUSrcA      = SRCA_PC;
    ALUSrcB      = SRCB_B;
    ExtOp        = 1'b0;
    ALUOperation = ALU_ADD;
    PCSource     = PCSRC_ALU;
    Illegal      = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemRead  = 1'b1;
        IRWrite  = 1'b1;
        ALUSrcA  = SRCA_PC;
        ALUSrcB  = SRCB_FOUR;
        PCSource = PCSRC_ALU;
        PCEnable = 1'b1;
        state_d  = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_PC;
        ALUSrcB = SRCB_BTGT;
        ExtOp   = 1'b1;
        unique case (1'b1)
          is_r:            state_d = S_R_EXEC;
          is_lw, is_sw:    state_d = S_MEM_ADDR;
          is_beq, is_bne:  state_d = S_BRANCH;
          is_j:            state_d = S_JUMP;
          is_addi,
          is_andi, is_ori: state_d = S_I_EXEC;
          default: begin
            state_d = S_FETCH;
            Illegal = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR: begin
        ALUSrcA = SRCA_A;
        ALUSrcB = SRCB_IMM;
        ExtOp   = 1'b1;
        if (is_sw)      state_d = S_MEM_WRITE;
        else if (is_lw) state_d = S_MEM_READ;
      end
      S_MEM_READ: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
        state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      S_MEM_WRITE: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      S_R_EXEC: begin
        ALUSrcA      = r_src_a_is_b ? SRCA_B : SRCA_A;
        ALUSrcB      = SRCB_B;
        ALUOperation = r_alu_op;
        state_d      = S_R_WB;
      end
      S_R_WB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA      = SRCA_A;
        ALUSrcB      = SRCB_B;
        ALUOperation = ALU_SUB;
        PCSource     = PCSRC_ALUOUT;
        if (is_beq)      PCEnable = Zero;
        else if (is_bne) PCEnable = ~Zero;
      end
      S_JUMP: begin
        PCSource = PCSRC_JUMP;
        PCEnable = 1'b1;
      end
      S_I_EXEC: begin
        ALUSrcA = SRCA_A;
        ALUSrcB = SRCB_IMM;
        unique case (1'b1)
          is_andi: ALUOperation = ALU_AND;
          is_ori:  ALUOperation = ALU_OR;
          default: begin
            ALUOperation = ALU_ADD;
            ExtOp        = 1'b1;
          end
        endcase
        state_d = S_I_WB;
      end
      S_I_WB: begin
        RegWrite = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
    // an asserted reset must never let a write escape
    if (reset) begin
      PCEnable = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
      Illegal  = 1'b0;
    end
  end

endmodule
